// File: rtl/cube_face_shader.sv
// cube_face_shader: registered per-pixel face colouring plus the cube's visit-state machine.
// Optional feature macro CUBE_SHADE_QUADRANT_EN halves the intensity of left-hand top quadrants.
module cube_face_shader #(
    parameter logic [23:0] COLOR_TOP0      = 24'h3050C0,
    parameter logic [23:0] COLOR_TOP1      = 24'hE0D020,
    parameter logic [23:0] COLOR_FLASH     = 24'hFFFFFF,
    parameter logic [23:0] COLOR_LEFT      = 24'h806040,
    parameter logic [23:0] COLOR_RIGHT     = 24'h403020,
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned FLASH_FRAMES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       level_reset,
    input  logic [3:0] top_face,
    input  logic       left_face,
    input  logic       right_face,
    input  logic       qbert_top_face,
    output logic       pix_valid,
    output logic [7:0] pix_r,
    output logic [7:0] pix_g,
    output logic [7:0] pix_b,
    output logic       visited,
    output logic [7:0] hit_count
);

    typedef enum logic [1:0] {
        ST_UNTOUCHED = 2'd0,
        ST_CONTACT   = 2'd1,
        ST_FLASH     = 2'd2,
        ST_VISITED   = 2'd3
    } state_e;

    localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE_FRAMES);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_FRAMES);

    state_e      state_q, state_d;
    logic [3:0]  deb_cnt_q, deb_cnt_d;
    logic [7:0]  flash_cnt_q, flash_cnt_d;
    logic        visited_q, visited_d;
    logic [7:0]  hit_count_q, hit_count_d;
    logic        qbert_prev_q;
    logic        pix_valid_q, pix_valid_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;
    logic [23:0] top_color;
    logic [7:0]  hit_count_inc;

    assign hit_count_inc = (hit_count_q == 8'hFF) ? 8'hFF : hit_count_q + 8'd1;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        flash_cnt_d = flash_cnt_q;
        visited_d   = visited_q;
        hit_count_d = hit_count_q;

        if (level_reset) begin
            state_d     = ST_UNTOUCHED;
            deb_cnt_d   = 4'd0;
            flash_cnt_d = 8'd0;
            visited_d   = 1'b0;
        end else begin
            case (state_q)
                ST_UNTOUCHED: begin
                    if (qbert_top_face) begin
                        state_d   = ST_CONTACT;
                        deb_cnt_d = 4'd0;
                    end
                end
                ST_CONTACT: begin
                    // A drop in the same cycle as frame_start abandons the landing uncounted.
                    if (!qbert_top_face) begin
                        state_d = ST_UNTOUCHED;
                    end else if (frame_start) begin
                        deb_cnt_d = deb_cnt_q + 4'd1;
                        if (deb_cnt_q + 4'd1 == DEB_LAST) begin
                            state_d     = ST_FLASH;
                            visited_d   = 1'b1;
                            hit_count_d = hit_count_inc;
                            flash_cnt_d = 8'd0;
                        end
                    end
                end
                ST_FLASH: begin
                    if (frame_start) begin
                        flash_cnt_d = flash_cnt_q + 8'd1;
                        if (flash_cnt_q + 8'd1 == FLASH_LAST) begin
                            state_d = ST_VISITED;
                        end
                    end
                end
                ST_VISITED: begin
                    if (qbert_top_face && !qbert_prev_q) begin
                        hit_count_d = hit_count_inc;
                    end
                end
                default: state_d = ST_UNTOUCHED;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            ST_FLASH:   top_color = COLOR_FLASH;
            ST_VISITED: top_color = COLOR_TOP1;
            default:    top_color = COLOR_TOP0;
        endcase

        pix_valid_d = 1'b0;
        pix_rgb_d   = 24'h000000;
        if (|top_face) begin
            pix_valid_d = 1'b1;
            pix_rgb_d   = top_color;
`ifdef CUBE_SHADE_QUADRANT_EN
            if (!top_face[0] && !top_face[2]) begin
                pix_rgb_d = {1'b0, top_color[23:17], 1'b0, top_color[15:9], 1'b0, top_color[7:1]};
            end
`endif
        end else if (left_face) begin
            pix_valid_d = 1'b1;
            pix_rgb_d   = COLOR_LEFT;
        end else if (right_face) begin
            pix_valid_d = 1'b1;
            pix_rgb_d   = COLOR_RIGHT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_UNTOUCHED;
            deb_cnt_q    <= 4'd0;
            flash_cnt_q  <= 8'd0;
            visited_q    <= 1'b0;
            hit_count_q  <= 8'd0;
            qbert_prev_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_rgb_q    <= 24'h000000;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            flash_cnt_q  <= flash_cnt_d;
            visited_q    <= visited_d;
            hit_count_q  <= hit_count_d;
            qbert_prev_q <= qbert_top_face;
            pix_valid_q  <= pix_valid_d;
            pix_rgb_q    <= pix_rgb_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_r     = pix_rgb_q[23:16];
    assign pix_g     = pix_rgb_q[15:8];
    assign pix_b     = pix_rgb_q[7:0];
    assign visited   = visited_q;
    assign hit_count = hit_count_q;

endmodule

// File: tb/tb_cube_face_shader.sv
// Bench for cube_face_shader: directed test-plan steps followed by random traffic,
// all checked against a frame-level behavioural model of the cube.
module tb_cube_face_shader;

    localparam logic [23:0] C_TOP0  = 24'h3050C0;
    localparam logic [23:0] C_TOP1  = 24'hE0D020;
    localparam logic [23:0] C_FLASH = 24'hFFFFFF;
    localparam logic [23:0] C_LEFT  = 24'h806040;
    localparam logic [23:0] C_RIGHT = 24'h403020;
    localparam int          DEB     = 2;
    localparam int          FLASHN  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       level_reset;
    logic [3:0] top_face;
    logic       left_face;
    logic       right_face;
    logic       qbert_top_face;
    logic       pix_valid;
    logic [7:0] pix_r, pix_g, pix_b;
    logic       visited;
    logic [7:0] hit_count;

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "init";

    // Behavioural model: a landing in progress, frames of flash left, visited flag, hits.
    bit          m_contact;
    int          m_contact_frames;
    int          m_flash_left;
    bit          m_visited;
    bit          m_prev;
    int          m_hits;
    logic        e_valid;
    logic [23:0] e_rgb;

    always #5 clk = ~clk;

    cube_face_shader dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .level_reset    (level_reset),
        .top_face       (top_face),
        .left_face      (left_face),
        .right_face     (right_face),
        .qbert_top_face (qbert_top_face),
        .pix_valid      (pix_valid),
        .pix_r          (pix_r),
        .pix_g          (pix_g),
        .pix_b          (pix_b),
        .visited        (visited),
        .hit_count      (hit_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_contact        = 1'b0;
        m_contact_frames = 0;
        m_flash_left     = 0;
        m_visited        = 1'b0;
        m_prev           = 1'b0;
        m_hits           = 0;
        e_valid          = 1'b0;
        e_rgb            = 24'h0;
    endtask

    function automatic logic [23:0] model_top_colour();
        if (m_flash_left > 0) return C_FLASH;
        if (m_visited)        return C_TOP1;
        return C_TOP0;
    endfunction

    // Called once per rising edge with the inputs that edge samples.
    task automatic model_step();
        logic [23:0] tc;
        tc = model_top_colour();
        if (top_face != 4'b0000) begin
            e_valid = 1'b1;
            e_rgb   = tc;
`ifdef CUBE_SHADE_QUADRANT_EN
            if ((top_face & 4'b0101) == 4'b0000) e_rgb = (tc >> 1) & 24'h7F7F7F;
`endif
        end else if (left_face) begin
            e_valid = 1'b1;
            e_rgb   = C_LEFT;
        end else if (right_face) begin
            e_valid = 1'b1;
            e_rgb   = C_RIGHT;
        end else begin
            e_valid = 1'b0;
            e_rgb   = 24'h0;
        end

        if (level_reset) begin
            m_contact        = 1'b0;
            m_contact_frames = 0;
            m_flash_left     = 0;
            m_visited        = 1'b0;
        end else if (m_flash_left > 0) begin
            if (frame_start) m_flash_left = m_flash_left - 1;
        end else if (m_visited) begin
            if (qbert_top_face && !m_prev) m_hits = (m_hits < 255) ? m_hits + 1 : 255;
        end else if (m_contact) begin
            if (!qbert_top_face) begin
                m_contact = 1'b0;
            end else if (frame_start) begin
                m_contact_frames = m_contact_frames + 1;
                if (m_contact_frames == DEB) begin
                    m_contact    = 1'b0;
                    m_visited    = 1'b1;
                    m_flash_left = FLASHN;
                    m_hits       = (m_hits < 255) ? m_hits + 1 : 255;
                end
            end
        end else if (qbert_top_face) begin
            m_contact        = 1'b1;
            m_contact_frames = 0;
        end
        m_prev = qbert_top_face;
    endtask

    task automatic check_outputs();
        check({phase, ".valid"}, 32'(pix_valid), 32'(e_valid));
        check({phase, ".rgb"}, 32'({pix_r, pix_g, pix_b}), 32'(e_rgb));
        check({phase, ".visited"}, 32'(visited), 32'(m_visited));
        check({phase, ".hits"}, 32'(hit_count), 32'(m_hits));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic frame_pulse(input int idle);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (idle) tick();
    endtask

    initial begin
        reset          = 1'b1;
        frame_start    = 1'b0;
        level_reset    = 1'b0;
        top_face       = 4'b0000;
        left_face      = 1'b0;
        right_face     = 1'b0;
        qbert_top_face = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        phase = "reset";
        check("reset.valid", 32'(pix_valid), 32'd0);
        check("reset.rgb", 32'({pix_r, pix_g, pix_b}), 32'd0);
        check("reset.visited", 32'(visited), 32'd0);
        check("reset.hits", 32'(hit_count), 32'd0);
        reset = 1'b0;

        phase = "pix_top0";
        top_face = 4'b0001;
        tick();
        check("pix_top0.const", 32'({pix_r, pix_g, pix_b}), 32'h3050C0);
        phase = "pix_none";
        top_face = 4'b0000;
        tick();
        phase = "pix_prio";
        top_face = 4'b0100; left_face = 1'b1;
        tick();
        phase = "pix_left";
        top_face = 4'b0000;
        tick();
        check("pix_left.const", 32'({pix_r, pix_g, pix_b}), 32'h806040);
        phase = "pix_right";
        left_face = 1'b0; right_face = 1'b1;
        tick();
        check("pix_right.const", 32'({pix_r, pix_g, pix_b}), 32'h403020);
        right_face = 1'b0;
        top_face   = 4'b0001;

        phase = "abort";
        qbert_top_face = 1'b1;
        tick();
        frame_pulse(2);
        qbert_top_face = 1'b0;
        repeat (2) tick();
        check("abort.visited", 32'(visited), 32'd0);
        check("abort.hits", 32'(hit_count), 32'd0);

        phase = "drop_vs_frame";
        qbert_top_face = 1'b1;
        tick();
        frame_pulse(1);
        qbert_top_face = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; qbert_top_face = 1'b1;
        tick();
        frame_pulse(2);
        check("drop_vs_frame.visited", 32'(visited), 32'd0);

        phase = "landing";
        frame_pulse(2);
        check("landing.visited", 32'(visited), 32'd1);
        check("landing.hits", 32'(hit_count), 32'd1);
        check("landing.flash", 32'({pix_r, pix_g, pix_b}), 32'hFFFFFF);
        phase = "flash";
        repeat (FLASHN) frame_pulse(3);
        check("flash.done", 32'({pix_r, pix_g, pix_b}), 32'hE0D020);

        phase = "saturate";
        repeat (300) begin
            qbert_top_face = 1'b0;
            tick();
            qbert_top_face = 1'b1;
            tick();
        end
        check("saturate.hits", 32'(hit_count), 32'd255);
        phase = "level_reset";
        level_reset = 1'b1;
        tick();
        level_reset = 1'b0;
        tick();
        check("level_reset.visited", 32'(visited), 32'd0);
        check("level_reset.rgb", 32'({pix_r, pix_g, pix_b}), 32'h3050C0);
        check("level_reset.hits", 32'(hit_count), 32'd255);
        qbert_top_face = 1'b0;
        repeat (2) tick();

        phase = "async_reset";
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_outputs();

        phase = "quadrant";
        top_face = 4'b1000;
        tick();
`ifdef CUBE_SHADE_QUADRANT_EN
        check("quadrant.left", 32'({pix_r, pix_g, pix_b}), 32'h182860);
`else
        check("quadrant.left", 32'({pix_r, pix_g, pix_b}), 32'h3050C0);
`endif
        top_face = 4'b0001;
        tick();
        check("quadrant.right", 32'({pix_r, pix_g, pix_b}), 32'h3050C0);

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) qbert_top_face = ~qbert_top_face;
            frame_start = ($urandom_range(0, 3) == 0);
            level_reset = ($urandom_range(0, 149) == 0);
            top_face    = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            left_face   = 1'($urandom_range(0, 1));
            right_face  = 1'($urandom_range(0, 1));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
